// File: rtl/blink_pkg.sv
// Shared mode encoding and pattern constants for the blink mode controller.
package blink_pkg;

    localparam int PAT_W = 8;
    localparam int IDX_W = $clog2(PAT_W);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_PATTERN = 2'd3
    } mode_e;

    function automatic mode_e next_mode(mode_e m);
        case (m)
            MODE_OFF:   return MODE_ON;
            MODE_ON:    return MODE_BLINK;
            MODE_BLINK: return MODE_PATTERN;
            default:    return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchroniser, stability-count debounce and
// a registered one-cycle pulse on each debounced press (release is ignored).
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/blink_mode_ctrl.sv
// Single-button LED mode controller: free-running prescaler plus a four-mode FSM.
//   state        | meaning
//   MODE_OFF     | led held low
//   MODE_ON      | led held high
//   MODE_BLINK   | led follows phase, toggled each tick
//   MODE_PATTERN | led walks PATTERN MSB first, one bit per tick
module blink_mode_ctrl
    import blink_pkg::*;
#(
    parameter int               TICK_DIV  = 5000000,
    parameter int               DB_CYCLES = 500000,
    parameter logic [PAT_W-1:0] PATTERN   = 8'b1010_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       led,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic             press;
    logic             tick_w;
    logic [PW-1:0]    presc_q, presc_d;
    mode_e            mode_q, mode_d;
    logic             phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             led_q, led_d;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    assign tick_w = (presc_q == PRESC_LAST);

    // A press wins over a coincident tick and restarts the prescaler.
    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        presc_d = tick_w ? '0 : presc_q + PW'(1);
        if (press) begin
            mode_d  = next_mode(mode_q);
            presc_d = '0;
            phase_d = 1'b1;
            idx_d   = IDX_W'(PAT_W - 1);
        end else if (tick_w) begin
            case (mode_q)
                MODE_BLINK:   phase_d = ~phase_q;
                MODE_PATTERN: idx_d   = idx_q - IDX_W'(1);
                default:      ;
            endcase
        end
    end

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_ON:      led_d = 1'b1;
            MODE_BLINK:   led_d = phase_q;
            MODE_PATTERN: led_d = PATTERN[idx_q];
            default:      led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            mode_q  <= MODE_OFF;
            phase_q <= 1'b0;
            idx_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = tick_w;

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// Directed scoreboard bench for blink_mode_ctrl with TICK_DIV=4, DB_CYCLES=3.
module tb_blink_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       led;
    logic       tick;
    logic [1:0] mode;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    bit exp_pat [8] = '{1, 0, 1, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    blink_mode_ctrl #(
        .TICK_DIV (4),
        .DB_CYCLES(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (btn),
        .led (led),
        .mode(mode),
        .tick(tick)
    );

    task automatic expect_v(string tag, logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(logic [31:0] obs);
        logic [31:0] e;
        string       tag;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    // Press the button, expect one step to exp_mode, then trace led for n_trace
    // cycles. kind: 0 const low, 1 const high, 2 blink, 3 pattern.
    task automatic do_press(int hold, logic [1:0] exp_mode, int kind, int n_trace, bit align);
        logic [1:0]  prev;
        logic [31:0] e;
        logic        coinc;
        int          lat;
        int          changes;
        int          w;
        if (align) begin
            w = 0;
            while (tick !== 1'b1 && w < 12) begin
                @(negedge clk);
                w++;
            end
            expect_v("align_tick", 1);
            check(tick);
            repeat (3) @(negedge clk);
        end
        expect_v("mode_step", exp_mode);
        expect_v("presc_entry", 0);
        expect_v("phase_entry", 1);
        expect_v("idx_entry", 7);
        for (int k = 0; k < n_trace; k++) begin
            case (kind)
                0:       e = 0;
                1:       e = 1;
                2:       e = ((k / 4) % 2 == 0) ? 1 : 0;
                default: e = exp_pat[(k / 4) % 8];
            endcase
            expect_v("led_trace", e);
        end
        btn     = 1'b1;
        prev    = mode;
        lat     = -1;
        changes = 0;
        coinc   = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (dut.press === 1'b1) coinc = tick;
            if (mode !== prev) begin
                changes++;
                prev = mode;
                if (lat < 0) begin
                    lat = i;
                    check(mode);
                    check(dut.presc_q);
                    check(dut.phase_q);
                    check(dut.idx_q);
                end
            end
            if (lat >= 0 && i > lat && i <= lat + n_trace) check(led);
            if (i == hold) btn = 1'b0;
            if (i >= hold + 12 && (lat < 0 || i >= lat + n_trace)) break;
        end
        if (lat < 0) begin
            check(mode);
            exp_q.delete();
            tag_q.delete();
        end
        expect_v("single_step", 1);
        check(changes);
        expect_v("latency_window", 1);
        check(lat >= 5 && lat <= 7);
        if (align) begin
            expect_v("press_on_tick", 1);
            check(coinc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npress;
        rst = 1'b0;
        btn = 1'b0;

        // Reset held while the button chatters.
        for (int i = 0; i < 8; i++) begin
            btn = ~btn;
            @(negedge clk);
            expect_v("rst_led", 0);
            expect_v("rst_mode", 0);
            expect_v("rst_tick", 0);
            check(led);
            check(mode);
            check(tick);
        end
        btn = 1'b0;
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            expect_v("post_rst_tick", (i % 4 == 3) ? 1 : 0);
            expect_v("post_rst_mode", 0);
            check(tick);
            check(mode);
        end

        // Two-cycle glitch must not register.
        npress = 0;
        btn    = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 2) btn = 1'b0;
            if (dut.press === 1'b1) npress++;
            expect_v("glitch_mode", 0);
            check(mode);
        end
        expect_v("glitch_press", 0);
        check(npress);

        do_press(10, 2'd1, 1, 8, 1'b0);
        do_press(6, 2'd2, 2, 40, 1'b0);
        do_press(6, 2'd3, 3, 64, 1'b0);
        do_press(6, 2'd0, 0, 8, 1'b0);

        // Presses landing on a tick.
        do_press(6, 2'd1, 1, 8, 1'b1);
        do_press(6, 2'd2, 2, 40, 1'b1);
        do_press(6, 2'd3, 3, 12, 1'b1);

        // Asynchronous reset mid-PATTERN while led is high.
        #1 rst = 1'b0;
        #1;
        expect_v("async_led", 0);
        expect_v("async_mode", 0);
        expect_v("async_tick", 0);
        check(led);
        check(mode);
        check(tick);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            expect_v("rerst_tick", (i % 4 == 3) ? 1 : 0);
            expect_v("rerst_mode", 0);
            check(tick);
            check(mode);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blink_mode_ctrl.md
BLINK_MODE_CTRL -- requirements
Module: blink_mode_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5000000, prescaler modulus in clk cycles (100 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter DB_CYCLES, default 500000, button debounce stability time in clk cycles; legal range >= 1.
REQ-003 SHALL have parameter PATTERN, default 8'b1010_0000, LED sequence for PATTERN mode, MSB first.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn  input  1  raw asynchronous push-button, active-high.
REQ-007 SHALL have port led  output  1  registered LED drive.
REQ-008 SHALL have port mode  output  2  current mode: 0 OFF, 1 ON, 2 BLINK, 3 PATTERN.
REQ-009 SHALL have port tick  output  1  one-cycle pulse at each prescaler wrap.

Function
REQ-010 SHALL synchronise btn through two flops before any other use.
REQ-011 SHALL update the debounced level only after DB_CYCLES consecutive synchronised samples that differ from it; any sample equal to the current debounced level restarts the count.
REQ-012 SHALL raise an internal one-cycle press pulse on each debounced 0->1 transition only; release generates no event.
REQ-013 SHALL count 0..TICK_DIV-1 with a $clog2(TICK_DIV)-bit prescaler, assert tick for the single cycle where count = TICK_DIV-1, then wrap to 0.
REQ-014 SHALL advance the mode FSM one step per press: OFF->ON->BLINK->PATTERN->OFF; no other transitions.
REQ-015 SHALL, on the cycle after a press, have mode updated, prescaler at 0, blink phase at 1 and pattern index at 7.
REQ-016 SHALL give press priority over a coincident tick: that tick does not change phase or index, and the prescaler restarts.
REQ-017 SHALL, in BLINK, toggle phase on every tick.
REQ-018 SHALL, in PATTERN, decrement the index on every tick, wrapping from 0 to 7.
REQ-019 SHALL register led one cycle after state: OFF 0; ON 1; BLINK phase; PATTERN PATTERN[index].
REQ-020 SHALL give a total btn-rise to mode-change latency of 2 + DB_CYCLES + 1 cycles, +/-1 for the sample edge.
REQ-021 SHALL run the prescaler continuously in every mode, including OFF and ON.

Reset
REQ-022 SHALL, while rst is low, immediately force mode=OFF, led=0 and tick=0, and clear the prescaler, debounce counter, debounced level, sync flops, phase and index.
REQ-023 SHALL take reset asynchronously mid-operation and restart the prescaler count from 0 on the first clk edge after release.

Structure
REQ-024 SHALL place the mode encoding (MODE_OFF/ON/BLINK/PATTERN, 2 bits) and pattern width constant (8) in the shared package blink_pkg.
REQ-025 SHALL implement synchronisation, debounce and edge detection in one sub-module btn_debounce (ports clk, rst, btn, press); the prescaler and FSM stay in the top module.

Verification (TICK_DIV=4, DB_CYCLES=3, PATTERN default)
REQ-026 SHALL verify reset: rst low with btn toggling -> led=0, mode=0, tick=0 throughout; after release, tick pulses every 4th cycle.
REQ-027 SHALL verify glitch rejection: btn high for 2 cycles only -> mode stays 0, no press pulse.
REQ-028 SHALL verify mode cycling: btn held 10 cycles -> mode=1 exactly once, led=1; three further clean presses -> mode 2, 3, 0, and led=0 at mode 0.
REQ-029 SHALL verify BLINK: led 1 on entry, then toggles each tick (4-cycle high/low) across 5 periods.
REQ-030 SHALL verify PATTERN: led sequence 1,0,1,0,0,0,0,0, each value held 4 cycles, repeating twice identically.
REQ-031 SHALL verify the corner cases: press coincident with tick -> prescaler reads 0 next cycle and phase/index take entry values; rst pulsed low mid-PATTERN -> led=0, mode=0 before the next clk edge.
